// File: rtl/ram_fifo_ctrl.sv
// 64-entry byte FIFO controller driving an external 64x8 single-port synchronous RAM.
// Optional sticky OVERFLOW output when RAM_FIFO_CTRL_OVF_FLAG_EN is defined.
module ram_fifo_ctrl #(
  parameter int unsigned ALMOST_FULL_LVL = 60
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DIN,
  input  logic       PUSH,
  output logic       PUSH_RDY,
  input  logic       POP,
  output logic       POP_RDY,
  output logic [7:0] DOUT,
  output logic       DOUT_VALID,
  output logic       FULL,
  output logic       EMPTY,
  output logic       ALMOST_FULL,
  output logic [7:0] RAM_DATA,
  output logic [5:0] RAM_ADDR,
  output logic       RAM_WE,
  input  logic [7:0] RAM_Q
`ifdef RAM_FIFO_CTRL_OVF_FLAG_EN
  ,
  output logic       OVERFLOW
`endif
);

  localparam logic [6:0] AfLvl = 7'(ALMOST_FULL_LVL);

  typedef enum logic {StIdle, StRdWait} state_e;

  state_e     state_q;
  logic [5:0] wr_ptr_q;
  logic [5:0] rd_ptr_q;
  logic [6:0] count_q;
  logic       push_acc;
  logic       pop_acc;

  always_comb begin
    FULL        = (count_q == 7'd64);
    EMPTY       = (count_q == 7'd0);
    ALMOST_FULL = (count_q >= AfLvl);
    // Pop wins the single RAM port; a simultaneous push waits a cycle.
    POP_RDY     = !RST && (state_q == StIdle) && !EMPTY;
    pop_acc     = POP && POP_RDY;
    PUSH_RDY    = !RST && !FULL && !pop_acc;
    push_acc    = PUSH && PUSH_RDY;
    RAM_WE      = push_acc;
    RAM_ADDR    = push_acc ? wr_ptr_q : rd_ptr_q;
    RAM_DATA    = DIN;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      wr_ptr_q   <= 6'd0;
      rd_ptr_q   <= 6'd0;
      count_q    <= 7'd0;
      DOUT       <= 8'h00;
      DOUT_VALID <= 1'b0;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + 6'd1;
      if (pop_acc)  rd_ptr_q <= rd_ptr_q + 6'd1;
      if (push_acc && !pop_acc)      count_q <= count_q + 7'd1;
      else if (pop_acc && !push_acc) count_q <= count_q - 7'd1;
      DOUT_VALID <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pop_acc) state_q <= StRdWait;
        end
        StRdWait: begin
          // RAM registered the read address at the accept edge; Q is valid now.
          DOUT       <= RAM_Q;
          DOUT_VALID <= 1'b1;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef RAM_FIFO_CTRL_OVF_FLAG_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      OVERFLOW <= 1'b0;
    end else if (PUSH && FULL) begin
      OVERFLOW <= 1'b1;
    end
  end
`endif

endmodule
